// File: rtl/hc00_pkg.sv
// rtl/hc00_pkg.sv - shared types and truth-table vectors for the quad NAND tester
package hc00_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Bit i of each table is the value for vector index i.
    localparam logic [NUM_VECTORS-1:0] VEC_A = 4'b1100;
    localparam logic [NUM_VECTORS-1:0] VEC_B = 4'b1010;
    localparam logic [NUM_VECTORS-1:0] VEC_Y = 4'b0111;

endpackage

// File: rtl/hc00_sync2.sv
// rtl/hc00_sync2.sv - multi-bit 2-flop synchronizer with synchronous reset
module hc00_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hc00_tester.sv
// rtl/hc00_tester.sv - drives the NAND truth table onto a quad gate and reports per-gate results
module hc00_tester
    import hc00_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [NUM_GATES-1:0] dut_a,
    output logic [NUM_GATES-1:0] dut_b,
    input  logic [NUM_GATES-1:0] dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [1:0]           fail_vec
);

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t               state;
    logic [7:0]           cnt;
    logic [1:0]           idx;
    logic [1:0]           next_idx;
    logic [NUM_GATES-1:0] y_sync;
    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] mism;
    logic [NUM_GATES-1:0] mask_next;

    hc00_sync2 #(.WIDTH(NUM_GATES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_y),
        .q   (y_sync)
    );

    assign next_idx  = idx + 2'd1;
    assign expected  = {NUM_GATES{VEC_Y[idx]}};
    assign mism      = y_sync ^ expected;
    assign mask_next = fail_mask | mism;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            dut_a     <= '0;
            dut_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx       <= '0;
                        dut_a     <= {NUM_GATES{VEC_A[0]}};
                        dut_b     <= {NUM_GATES{VEC_B[0]}};
                        fail_mask <= '0;
                        fail_vec  <= '0;
                        cnt       <= CNT_LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == 8'd0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CHECK: begin
                    fail_mask <= mask_next;
                    // Only the first failing vector is recorded.
                    if (mism != '0 && fail_mask == '0) begin
                        fail_vec <= idx;
                    end
                    if (idx != 2'd3) begin
                        idx   <= next_idx;
                        dut_a <= {NUM_GATES{VEC_A[next_idx]}};
                        dut_b <= {NUM_GATES{VEC_B[next_idx]}};
                        cnt   <= CNT_LOAD;
                        state <= SETTLE;
                    end else begin
                        dut_a <= '0;
                        dut_b <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mask_next == '0);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc00_tester.sv
// tb/tb_hc00_tester.sv - randomized and directed self-checking bench for hc00_tester
module tb_hc00_tester;

    localparam int NG        = 4;
    localparam int S         = 4;
    localparam int RUN_EDGES = 4 * (S + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NG-1:0] dut_a;
    logic [NG-1:0] dut_b;
    logic [NG-1:0] dut_y;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NG-1:0] fail_mask;
    logic [1:0]    fail_vec;

    int n_checks = 0;
    int n_errors = 0;

    // Gate models: truth table indexed by {a,b} and an output delay in clock cycles.
    logic [3:0] tt   [NG];
    int         dly  [NG];
    logic [7:0] pipe [NG];

    always #5 clk = ~clk;

    hc00_tester #(.NUM_GATES(NG), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_y     (dut_y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .fail_vec  (fail_vec)
    );

    always @(posedge clk) begin
        for (int g = 0; g < NG; g++) begin
            pipe[g] <= {pipe[g][6:0], tt[g][{dut_a[g], dut_b[g]}]};
        end
    end

    always_comb begin
        dut_y = '0;
        for (int g = 0; g < NG; g++) begin
            dut_y[g] = (dly[g] == 0) ? tt[g][{dut_a[g], dut_b[g]}] : pipe[g][dly[g] - 1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gate(input int g, input logic [3:0] t, input int d);
        tt[g]  = t;
        dly[g] = d;
    endtask

    task automatic all_nand();
        for (int g = 0; g < NG; g++) set_gate(g, 4'b0111, 0);
    endtask

    // Vector i is applied at edge i*(S+1) and its sync stage-1 capture sees inputs
    // applied up to S-2-d edges later; before the run the gates idle at A=B=0.
    task automatic predict(output logic [NG-1:0] m, output int fv);
        m  = '0;
        fv = -1;
        for (int i = 0; i < 4; i++) begin
            logic [NG-1:0] mm;
            mm = '0;
            for (int g = 0; g < NG; g++) begin
                int   t;
                int   j;
                int   a;
                int   b;
                logic y;
                logic e;
                t = i * (S + 1) + S - 2 - dly[g];
                j = (t < 0) ? -1 : t / (S + 1);
                a = (j < 0) ? 0 : (j >> 1);
                b = (j < 0) ? 0 : (j & 1);
                y = tt[g][a * 2 + b];
                e = !((i >> 1) == 1 && (i & 1) == 1);
                mm[g] = (y != e);
            end
            if (mm != '0 && fv < 0) fv = i;
            m |= mm;
        end
    endtask

    task automatic launch(input logic hold);
        start = 1'b1;
        tick();
        start = hold;
    endtask

    // Called just after the edge that sampled start; follows the run to done.
    task automatic run_check(input logic mid_start, input logic hold);
        logic [NG-1:0] em;
        int            ev;
        int            k;
        predict(em, ev);
        k = 0;
        while (!done && k < RUN_EDGES + 10) begin
            int vi;
            vi = k / (S + 1);
            check("busy_run", busy, 1);
            check("dut_a_run", dut_a, ((vi >> 1) & 1) ? {NG{1'b1}} : '0);
            check("dut_b_run", dut_b, (vi & 1) ? {NG{1'b1}} : '0);
            start = hold | (mid_start & (k == 7));
            tick();
            k++;
        end
        start = hold;
        check("latency", k, RUN_EDGES);
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("pass", pass, em == '0);
        check("fail_mask", fail_mask, em);
        if (em != '0) check("fail_vec", fail_vec, ev);
        check("dut_a_end", dut_a, 0);
        check("dut_b_end", dut_b, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        all_nand();
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_mask", fail_mask, 0);
        check("rst_vec", fail_vec, 0);
        check("rst_a", dut_a, 0);
        check("rst_b", dut_b, 0);
        rst = 1'b0;
        repeat (10) tick();

        // Ideal gates
        launch(1'b0);
        run_check(1'b0, 1'b0);
        check("ideal_pass", pass, 1);

        // Gate 2 stuck-at-1
        set_gate(2, 4'b1111, 0);
        repeat (10) tick();
        launch(1'b0);
        run_check(1'b0, 1'b0);
        check("st1_mask", fail_mask, 4'b0100);
        check("st1_vec", fail_vec, 3);

        // Gate 0 stuck-at-0, gate 1 wired as AND
        all_nand();
        set_gate(0, 4'b0000, 0);
        set_gate(1, 4'b1000, 0);
        repeat (10) tick();
        launch(1'b0);
        run_check(1'b0, 1'b0);
        check("two_mask", fail_mask, 4'b0011);
        check("two_vec", fail_vec, 0);

        // Gate 3 delay at and beyond the guaranteed window
        all_nand();
        set_gate(3, 4'b0111, 2);
        repeat (10) tick();
        launch(1'b0);
        run_check(1'b0, 1'b0);
        check("dly2_pass", pass, 1);
        set_gate(3, 4'b0111, 4);
        repeat (10) tick();
        launch(1'b0);
        run_check(1'b0, 1'b0);
        check("dly4_mask", fail_mask, 4'b1000);

        // Reset during idx2 SETTLE after a failure is already recorded
        all_nand();
        set_gate(0, 4'b0000, 0);
        repeat (10) tick();
        launch(1'b0);
        repeat (11) tick();
        check("mid_mask", fail_mask, 4'b0001);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_a", dut_a, 0);
        check("abort_b", dut_b, 0);
        check("abort_mask", fail_mask, 0);
        all_nand();
        repeat (10) tick();
        launch(1'b0);
        run_check(1'b0, 1'b0);
        check("post_rst_pass", pass, 1);

        // Start pulse mid-run must not disturb timing
        launch(1'b0);
        run_check(1'b1, 1'b0);

        // Back-to-back: fail, then start held high from DONE
        set_gate(1, 4'b1000, 0);
        repeat (10) tick();
        launch(1'b0);
        run_check(1'b0, 1'b0);
        all_nand();
        start = 1'b1;
        tick();
        check("b2b_done", done, 0);
        check("b2b_busy", busy, 1);
        check("b2b_mask", fail_mask, 0);
        check("b2b_pass", pass, 0);
        run_check(1'b0, 1'b1);
        tick();
        check("b2b2_done", done, 0);
        check("b2b2_busy", busy, 1);
        start = 1'b0;
        run_check(1'b0, 1'b0);

        // Randomized gate functions and delays
        for (int r = 0; r < 10; r++) begin
            for (int g = 0; g < NG; g++) begin
                set_gate(g, ($urandom_range(0, 1) == 1) ? 4'b0111 : 4'($urandom),
                         int'($urandom_range(0, 6)));
            end
            repeat (10) tick();
            launch(1'b0);
            run_check(1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hc00_tester.md
Name: hc00_tester

Overview:
- Self-contained stimulus/response tester for a quad 2-input NAND device (74HC00 footprint or its FPGA equivalent).
- Drives the device's A/B inputs through the full 2-input truth table and samples its Y outputs after a programmable settle time.
- Reports per-gate pass/fail. Sits on the board-test / bring-up side, opposite the NAND gates it exercises.

Parameters:
- NUM_GATES, 4, number of independent NAND gates under test (74HC00 = 4).
- SETTLE_CYCLES, 4, clk cycles between driving a vector and checking it. Legal range 3..255; values below 3 are illegal because of the 2-flop synchronizer.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  run request, sampled in IDLE and DONE only.
- dut_a  out  NUM_GATES  A inputs to the gates (registered).
- dut_b  out  NUM_GATES  B inputs to the gates (registered).
- dut_y  in  NUM_GATES  Y outputs from the gates; asynchronous to clk.
- busy  out  1  run in progress.
- done  out  1  run complete; results valid; held until next start or reset.
- pass  out  1  done and fail_mask == 0.
- fail_mask  out  NUM_GATES  bit g set if gate g mismatched on any vector.
- fail_vec  out  2  index of the first vector with any mismatch; valid when done and fail_mask != 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst takes priority over everything.
- Reset values:
  - State IDLE.
  - dut_a = dut_b = 0; busy = done = pass = 0; fail_mask = 0; fail_vec = 0.
  - Settle counter 0; vector index 0; synchronizer flops 0.
- Vector order: all gates driven identically.
  - idx0: A=0, B=0, expect Y=1
  - idx1: A=0, B=1, expect Y=1
  - idx2: A=1, B=0, expect Y=1
  - idx3: A=1, B=1, expect Y=0
- dut_y passes through a 2-flop synchronizer before comparison.
- States:
  - IDLE: on start, load idx0 onto dut_a/dut_b, clear fail_mask and fail_vec, set cnt = SETTLE_CYCLES-1, set busy, go to SETTLE.
  - SETTLE: decrement cnt each cycle. When cnt == 0, go to CHECK.
  - CHECK (one cycle):
    - mism = y_sync XOR expected. fail_mask |= mism.
    - If mism != 0 and fail_mask was 0 before this check, capture fail_vec = idx.
    - If idx < 3: idx++, drive the next vector, cnt = SETTLE_CYCLES-1, go to SETTLE.
    - If idx == 3: drive A=B=0, clear busy, set done, go to DONE.
  - DONE: outputs held. start behaves as in IDLE, clearing done/pass and starting a new run in the same edge.
- Latency: done rises 4*(SETTLE_CYCLES+1) rising edges after the edge that samples start (20 edges at default).
- pass is registered with done: pass = (fail_mask_next == 0) on the transition into DONE.
- start during SETTLE/CHECK is ignored; no queuing. start held high runs back-to-back, with one DONE cycle between runs.
- Gate response constraint: a gate whose Y settles within SETTLE_CYCLES-2 cycles of its A/B edge must pass. Slower gates may fail; this is intended detection behaviour.
- Reset mid-run aborts immediately. All outputs return to reset values on the next edge; no partial results are retained.

Decomposition:
- Package hc00_pkg:
  - state enum {IDLE, SETTLE, CHECK, DONE}
  - NUM_VECTORS = 4
  - constant vector tables VEC_A = 4'b1100, VEC_B = 4'b1010, VEC_Y = 4'b0111 (indexed by idx)
- One sub-module, hc00_sync2: NUM_GATES-wide 2-flop synchronizer for dut_y, with synchronous reset to 0.

Test Plan:
- Ideal zero-delay NAND model on all 4 gates, start pulse → busy for 20 cycles; done = 1, pass = 1, fail_mask = 4'b0000, dut_a/dut_b sequence 00,01,10,11 per gate.
- Gate 2 Y stuck-at-1 → done, pass = 0, fail_mask = 4'b0100, fail_vec = 3.
- Gate 0 Y stuck-at-0 and gate 1 wired as AND → fail_mask = 4'b0011, fail_vec = 0 (first failing vector).
- SETTLE_CYCLES = 4; model gate 3 with 2-cycle delay → pass; gate 3 with 4-cycle delay → fail_mask bit 3 set.
- rst asserted during idx2 SETTLE → next edge: busy = 0, done = 0, dut_a = dut_b = 0, fail_mask = 0. A following start runs a clean full sequence and passes.
- start pulsed mid-run (ignored, no timing change); then start held high after done → new run begins on the DONE edge, done drops, results are cleared and then re-reported 20 edges later.
